// File: rtl/turn_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : turn_sched
// Brief    : Two-player turn scheduler with per-turn countdown, holder-only
//            grant forwarding and a one-cycle expiry pulse.
// Revision : 1.0 - initial release
// ============================================================================
module turn_sched #(
    parameter int SEC_CYCLES = 50000000,
    parameter int PRE_W      = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       reconf,
    input  logic [3:0] cfg_digit,
    input  logic       cfg_enter,
    input  logic       req_1,
    input  logic       req_R,
    output logic       grant_1,
    output logic       grant_R,
    output logic       turn,
    output logic [3:0] time_left,
    output logic       timeout
);

    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(SEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_RUN      = 3'd2,
        S_EXPIRE   = 3'd3,
        S_WAIT_DIS = 3'd4
    } state_t;

    state_t           r_state;
    logic [3:0]       r_limit;
    logic [PRE_W-1:0] r_pre;
    logic             r_grant_1;
    logic             r_grant_R;
    logic             r_turn;
    logic [3:0]       r_time_left;
    logic             r_timeout;

    logic w_holder_req;
    logic w_tick;

    assign w_holder_req = r_turn ? req_R : req_1;
    assign w_tick       = (r_pre == c_PRE_MAX);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_limit     <= 4'd10;
            r_pre       <= '0;
            r_grant_1   <= 1'b0;
            r_grant_R   <= 1'b0;
            r_turn      <= 1'b0;
            r_time_left <= 4'd0;
            r_timeout   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_grant_1 <= 1'b0;
            r_grant_R <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (reconf && cfg_enter) begin
                        r_limit <= (cfg_digit == 4'd0) ? 4'd15 : cfg_digit;
                    end
                    if (enable) begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_time_left <= r_limit;
                    r_pre       <= '0;
                    r_turn      <= 1'b0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (!enable) begin
                        r_time_left <= 4'd0;
                        r_state     <= S_IDLE;
                    end else if (w_holder_req) begin
                        // A grant beats a coincident expiring tick
                        r_grant_1   <= ~r_turn;
                        r_grant_R   <= r_turn;
                        r_turn      <= ~r_turn;
                        r_time_left <= r_limit;
                        r_pre       <= '0;
                    end else if (w_tick) begin
                        r_pre <= '0;
                        if (r_time_left <= 4'd1) begin
                            r_time_left <= 4'd0;
                            r_timeout   <= 1'b1;
                            r_state     <= S_EXPIRE;
                        end else begin
                            r_time_left <= r_time_left - 4'd1;
                        end
                    end else begin
                        r_pre <= r_pre + PRE_W'(1);
                    end
                end
                S_EXPIRE: begin
                    r_state <= S_WAIT_DIS;
                end
                S_WAIT_DIS: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_1   = r_grant_1;
    assign grant_R   = r_grant_R;
    assign turn      = r_turn;
    assign time_left = r_time_left;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire
